mixer_seq: RTL and testbench

- Analog power/bias sequencer between the mixer control register block and the analog mixer pins.
- The register block supplies requested pd/ota/buff levels. This block applies them to the analog macro in a fixed safe order, inserting programmable settling delays between steps.
- Reports busy so firmware can poll for settling completion.

---
 rtl/mixer_seq.sv | 148 ++++++++++++++
 tb/tb_mixer_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mixer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_seq
//  Description : Power/bias sequencer for the analog mixer. Applies the
//                requested pd/ota/buff levels in a safe order and holds off
//                a programmable settling time after each step. busy is high
//                while a sequence is running.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixer_seq #(
    parameter int unsigned T_PD   = 100,
    parameter int unsigned T_OTA  = 50,
    parameter int unsigned T_BUFF = 20,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_req,
    input  logic       ota_req,
    input  logic [1:0] buff_req,
    output logic       pd_o,
    output logic       ota_o,
    output logic [1:0] buff_o,
    output logic       busy
);

    // Counter load values: a step of T cycles counts T-1 down to 0.
    localparam logic [CNT_W-1:0] LD_PD   = CNT_W'(T_PD - 1);
    localparam logic [CNT_W-1:0] LD_OTA  = CNT_W'(T_OTA - 1);
    localparam logic [CNT_W-1:0] LD_BUFF = CNT_W'(T_BUFF - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        UP_PD    = 4'd1,
        UP_OTA   = 4'd2,
        UP_BUFF  = 4'd3,
        DN_BUFF  = 4'd4,
        DN_OTA   = 4'd5,
        DN_PD    = 4'd6,
        UPD_OTA  = 4'd7,
        UPD_BUFF = 4'd8
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ota_lat;
    logic [1:0]       buff_lat;

    // Sequencer: each step drives its output on entry, then settles for T_x
    // cycles; requests are only sampled in IDLE and latched on IDLE exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pd_o     <= 1'b1;
            ota_o    <= 1'b0;
            buff_o   <= 2'b00;
            busy     <= 1'b0;
            ota_lat  <= 1'b0;
            buff_lat <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (pd_req && !pd_o) begin
                        // Power down: buffers off first, then OTA, then pd.
                        state    <= DN_BUFF;
                        buff_o   <= 2'b00;
                        cnt      <= LD_BUFF;
                        busy     <= 1'b1;
                        ota_lat  <= ota_req;
                        buff_lat <= buff_req;
                    end else if (!pd_req && pd_o) begin
                        // Power up: release pd first; all three steps run.
                        state    <= UP_PD;
                        pd_o     <= 1'b0;
                        cnt      <= LD_PD;
                        busy     <= 1'b1;
                        ota_lat  <= ota_req;
                        buff_lat <= buff_req;
                    end else if (!pd_req && !pd_o && (ota_req != ota_o)) begin
                        // Update while powered up, OTA step always first.
                        state    <= UPD_OTA;
                        ota_o    <= ota_req;
                        cnt      <= LD_OTA;
                        busy     <= 1'b1;
                        ota_lat  <= ota_req;
                        buff_lat <= buff_req;
                    end else if (!pd_req && !pd_o && (buff_req != buff_o)) begin
                        state    <= UPD_BUFF;
                        buff_o   <= buff_req;
                        cnt      <= LD_BUFF;
                        busy     <= 1'b1;
                        ota_lat  <= ota_req;
                        buff_lat <= buff_req;
                    end
                end

                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Settling done: advance to the next step or finish.
                        case (state)
                            UP_PD: begin
                                state <= UP_OTA;
                                ota_o <= ota_lat;
                                cnt   <= LD_OTA;
                            end
                            UP_OTA: begin
                                state  <= UP_BUFF;
                                buff_o <= buff_lat;
                                cnt    <= LD_BUFF;
                            end
                            DN_BUFF: begin
                                state <= DN_OTA;
                                ota_o <= 1'b0;
                                cnt   <= LD_OTA;
                            end
                            DN_OTA: begin
                                state <= DN_PD;
                                pd_o  <= 1'b1;
                                cnt   <= LD_PD;
                            end
                            UPD_OTA: begin
                                if (buff_lat != buff_o) begin
                                    state  <= UPD_BUFF;
                                    buff_o <= buff_lat;
                                    cnt    <= LD_BUFF;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                            default: begin
                                // UP_BUFF, DN_PD, UPD_BUFF end the sequence.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mixer_seq
//  Description : Self-checking bench for mixer_seq against a step-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_seq;

    localparam int TP = 8;
    localparam int TO = 4;
    localparam int TB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pd_req;
    logic       ota_req;
    logic [1:0] buff_req;
    logic       pd_o;
    logic       ota_o;
    logic [1:0] buff_o;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mixer_seq #(
        .T_PD  (TP),
        .T_OTA (TO),
        .T_BUFF(TB),
        .CNT_W (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pd_req  (pd_req),
        .ota_req (ota_req),
        .buff_req(buff_req),
        .pd_o    (pd_o),
        .ota_o   (ota_o),
        .buff_o  (buff_o),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence is a list of (output, value, duration)
    // steps built when the model is idle, then played out one by one.
    typedef struct {
        int         kind;   // 0 = pd, 1 = ota, 2 = buff
        logic [1:0] val;
        int         dur;
    } step_t;

    step_t      plan[$];
    logic       m_pd   = 1'b1;
    logic       m_ota  = 1'b0;
    logic [1:0] m_buff = 2'b00;
    logic       m_busy = 1'b0;
    int         rem    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_next();
        step_t s;
        s = plan.pop_front();
        case (s.kind)
            0:       m_pd   = s.val[0];
            1:       m_ota  = s.val[0];
            default: m_buff = s.val;
        endcase
        rem    = s.dur;
        m_busy = 1'b1;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pd = 1'b1; m_ota = 1'b0; m_buff = 2'b00; m_busy = 1'b0;
            rem = 0;
            plan.delete();
        end else if (!m_busy) begin
            if (pd_req && !m_pd) begin
                plan.push_back('{2, 2'd0, TB});
                plan.push_back('{1, 2'd0, TO});
                plan.push_back('{0, 2'd1, TP});
            end else if (!pd_req && m_pd) begin
                plan.push_back('{0, 2'd0, TP});
                plan.push_back('{1, {1'b0, ota_req}, TO});
                plan.push_back('{2, buff_req, TB});
            end else if (!pd_req && !m_pd) begin
                if (ota_req != m_ota)   plan.push_back('{1, {1'b0, ota_req}, TO});
                if (buff_req != m_buff) plan.push_back('{2, buff_req, TB});
            end
            if (plan.size() > 0) apply_next();
        end else begin
            rem--;
            if (rem == 0) begin
                if (plan.size() > 0) apply_next();
                else                 m_busy = 1'b0;
            end
        end
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pd_o",   {31'd0, pd_o},   {31'd0, m_pd});
        chk("ota_o",  {31'd0, ota_o},  {31'd0, m_ota});
        chk("buff_o", {30'd0, buff_o}, {30'd0, m_buff});
        chk("busy",   {31'd0, busy},   {31'd0, m_busy});
        chk("order_pd_gates", {31'd0, pd_o && (ota_o || buff_o != 2'b00)}, 32'd0);
    endtask

    // Start edge plus busy cycles until idle, bounded.
    task automatic run_seq(input string tag, input int exp_busy);
        int n;
        n = 0;
        step_cycle();
        for (int k = 0; k < 500 && busy; k++) begin
            n++;
            step_cycle();
        end
        chk({tag, "_busy_len"}, n, exp_busy);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"},   {31'd0, pd_o},   32'd1);
        chk({tag, "_ota"},  {31'd0, ota_o},  32'd0);
        chk({tag, "_buff"}, {30'd0, buff_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy},   32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; pd_req = 1'b0; ota_req = 1'b1; buff_req = 2'b11;

        step_cycle(); chk_reset_vals("rst0");
        step_cycle(); chk_reset_vals("rst1");
        rst = 1'b0;

        // Power-up: pd at E, ota at E+8, buff at E+12, idle at E+14.
        run_seq("pwr_up", TP + TO + TB);
        chk("pu_pd",   {31'd0, pd_o},   32'd0);
        chk("pu_ota",  {31'd0, ota_o},  32'd1);
        chk("pu_buff", {30'd0, buff_o}, 32'd3);

        pd_req = 1'b1;
        run_seq("pwr_dn", TP + TO + TB);
        chk_reset_vals("pd_done");

        pd_req = 1'b0;
        run_seq("pwr_up2", TP + TO + TB);

        buff_req = 2'b01;
        run_seq("upd_buff", TB);
        chk("ub_ota",  {31'd0, ota_o},  32'd1);
        chk("ub_buff", {30'd0, buff_o}, 32'd1);

        ota_req = 1'b0; buff_req = 2'b10;
        run_seq("upd_both", TO + TB);
        chk("uo_ota",  {31'd0, ota_o},  32'd0);
        chk("uo_buff", {30'd0, buff_o}, 32'd2);

        pd_req = 1'b1;
        run_seq("pwr_dn2", TP + TO + TB);

        // pd_req raised mid power-up: power-up finishes, then power-down runs.
        pd_req = 1'b0; ota_req = 1'b1; buff_req = 2'b11;
        step_cycle(); step_cycle(); step_cycle();
        n = 2;
        pd_req = 1'b1;
        for (int k = 0; k < 500 && busy; k++) begin
            n++;
            step_cycle();
        end
        chk("mid_toggle_up_len", n, TP + TO + TB);
        run_seq("mid_toggle_dn", TP + TO + TB);
        chk_reset_vals("mid_toggle_end");

        // Powered down and held: ota/buff requests are ignored.
        for (int k = 0; k < 4; k++) begin
            ota_req  = ~ota_req;
            buff_req = buff_req + 2'd1;
            run_seq("pd_hold", 0);
        end

        // Reset in the middle of a power-up aborts to reset values.
        pd_req = 1'b0;
        for (int k = 0; k < 5; k++) step_cycle();
        rst = 1'b1;
        step_cycle();
        chk_reset_vals("rst_mid");
        rst = 1'b0;

        // Random phase: sparse request changes and rare resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) begin
                pd_req   = ($urandom_range(0, 3) == 0);
                ota_req  = 1'($urandom);
                buff_req = 2'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step_cycle();
        end
        rst = 1'b0;
        step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
